// File: rtl/ysyx_23060171_pkg.sv
// Shared constants for the NPC write-back arbiter and register scoreboard.
package ysyx_23060171_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;

    localparam logic WB_REQ_EXU = 1'b0;
    localparam logic WB_REQ_LSU = 1'b1;

    localparam int                  SB_CNT_W   = 2;
    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;

endpackage

// File: rtl/ysyx_23060171_scoreboard.sv
// Per-register pending-write counters; produces the mark backpressure and the
// read-after-write hazard flag seen by IDU.
module ysyx_23060171_scoreboard #(
    parameter int ADDR_WIDTH = ysyx_23060171_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    output logic                  set_ready,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs_hazard,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr
);
    import ysyx_23060171_pkg::*;

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [SB_CNT_W-1:0] cnt [NREG];
    logic                mark_fire;

    assign cnt[0]    = '0;
    assign set_ready = ~rst & ((set_addr == '0) | (cnt[set_addr] != SB_CNT_MAX));
    assign mark_fire = set_valid & set_ready & (set_addr != '0);

    assign rs_hazard = ((rs1_addr != '0) & (cnt[rs1_addr] != '0))
                     | ((rs2_addr != '0) & (cnt[rs2_addr] != '0));

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
            logic [SB_CNT_W-1:0] cnt_q;
            logic [SB_CNT_W-1:0] cnt_d;
            logic                inc;
            logic                dec;

            assign inc = mark_fire & (set_addr == ADDR_WIDTH'(gi));
            assign dec = clr_en & (clr_addr == ADDR_WIDTH'(gi));

            // A retire with nothing outstanding leaves the counter at zero.
            always_comb begin
                cnt_d = cnt_q;
                if (inc && !dec) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (dec && !inc && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt[gi] = cnt_q;
        end
    endgenerate

endmodule

// File: rtl/ysyx_23060171_wb_arbiter.sv
// Two-source write-back arbiter driving the register-file write port.
// Define YSYX_23060171_WB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_23060171_wb_arbiter #(
    parameter int ADDR_WIDTH = ysyx_23060171_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ysyx_23060171_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    output logic                  set_ready,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs_hazard,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    import ysyx_23060171_pkg::*;

    logic                  grant0;
    logic                  grant1;
    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

`ifdef YSYX_23060171_WB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = (rr_ptr_q == WB_REQ_EXU);
                grant1 = (rr_ptr_q == WB_REQ_LSU);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        if (grant0) rr_ptr_d = WB_REQ_LSU;
        if (grant1) rr_ptr_d = WB_REQ_EXU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= WB_REQ_EXU;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign grant1 = ~rst & req1_valid;
    assign grant0 = ~rst & req0_valid & ~req1_valid;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Writes to x0 still handshake but never reach the register file.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant1) begin
            wen_d   = (req1_addr != '0);
            waddr_d = req1_addr;
            wdata_d = req1_data;
        end else if (grant0) begin
            wen_d   = (req0_addr != '0);
            waddr_d = req0_addr;
            wdata_d = req0_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_wen   = wen_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    ysyx_23060171_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_addr  (set_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs_hazard (rs_hazard),
        .clr_en    (wen_q),
        .clr_addr  (waddr_q)
    );

endmodule

// File: tb/tb_ysyx_23060171_wb_arbiter.sv
// Directed self-checking bench for the write-back arbiter and scoreboard.
module tb_ysyx_23060171_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_valid;
    logic        set_ready;
    logic [4:0]  set_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs_hazard;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_23060171_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .set_valid  (set_valid),
        .set_ready  (set_ready),
        .set_addr   (set_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs_hazard  (rs_hazard),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        set_valid  = 1'b0; set_addr  = '0;
        rs1_addr   = '0;   rs2_addr  = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        set_valid  = 1'b1; set_addr  = 5'd3; rs1_addr = 5'd3;
        tick(); tick();
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
        n_tests++; if (set_ready !== 1'b0) begin n_fail++; $display("FAIL reset_set_ready: got %b want 0", set_ready); end
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
        n_tests++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
        n_tests++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_rs_hazard: got %b want 0", rs_hazard); end
        idle_inputs();
        rst = 1'b0;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_req0_ready: got %b want 1", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_req1_ready: got %b want 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        n_tests++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL single_rf_wen: got %b want 1", rf_wen); end
        n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL single_rf_waddr: got %0d want 5", rf_waddr); end
        n_tests++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf_wdata: got %h want deadbeef", rf_wdata); end
        tick();
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL single_rf_wen_drop: got %b want 0", rf_wen); end
        $display("[TB] test_single_write done");
    endtask

    task automatic test_hazard();
        set_valid = 1'b1; set_addr = 5'd7; rs1_addr = 5'd7;
        #1;
        n_tests++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_set_ready: got %b want 1", set_ready); end
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_mark_cycle: got %b want 0", rs_hazard); end
        tick();
        set_valid = 1'b0;
        #1;
        n_tests++; if (rs_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_raised: got %b want 1", rs_hazard); end
        tick(); tick();
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_0077;
        #1;
        n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_req1_ready: got %b want 1", req1_ready); end
        n_tests++; if (rs_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_hs_cycle: got %b want 1", rs_hazard); end
        tick();
        req1_valid = 1'b0;
        #1;
        n_tests++; if (rs_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_wen_cycle: got %b want 1", rs_hazard); end
        n_tests++; if (rf_waddr !== 5'd7) begin n_fail++; $display("FAIL hazard_rf_waddr: got %0d want 7", rf_waddr); end
        tick();
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_cleared: got %b want 0", rs_hazard); end
        rs1_addr = '0;
        $display("[TB] test_hazard done");
    endtask

    task automatic test_saturation();
        rs2_addr = 5'd9;
        set_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            set_valid = 1'b1;
            #1;
            n_tests++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL sat_mark%0d_ready: got %b want 1", i, set_ready); end
            tick();
        end
        #1;
        n_tests++; if (set_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full_ready: got %b want 0", set_ready); end
        n_tests++; if (rs_hazard !== 1'b1) begin n_fail++; $display("FAIL sat_rs2_hazard: got %b want 1", rs_hazard); end
        tick();
        set_valid = 1'b0;
        // one retire: cnt 3 -> 2, visible two cycles after the handshake
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9;
        tick();
        req0_valid = 1'b0;
        #1;
        n_tests++; if (set_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready_wen_cycle: got %b want 0", set_ready); end
        tick();
        n_tests++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready_after_retire: got %b want 1", set_ready); end
        // mark accepted in the same cycle the output stage retires x9
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        set_valid  = 1'b1;
        tick();
        set_valid = 1'b0;
        #1;
        n_tests++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL sat_same_cycle_cnt2: got %b want 1", set_ready); end
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        #1;
        n_tests++; if (set_ready !== 1'b0) begin n_fail++; $display("FAIL sat_refill_cnt3: got %b want 0", set_ready); end
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'(i);
            #1;
            n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL sat_b2b_ready%0d: got %b want 1", i, req1_ready); end
            tick();
        end
        req1_valid = 1'b0;
        #1;
        n_tests++; if (rs_hazard !== 1'b1) begin n_fail++; $display("FAIL sat_drain_last: got %b want 1", rs_hazard); end
        tick();
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL sat_drained: got %b want 0", rs_hazard); end
        rs2_addr = '0; set_addr = '0;
        $display("[TB] test_saturation done");
    endtask

    task automatic test_contention();
        logic       exp0, exp1;
        logic [4:0] exp_addr;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060171_WB_RR_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = 1'b1;
`endif
            exp0     = ~exp1;
            exp_addr = exp1 ? 5'd11 : 5'd10;
            #1;
            n_tests++; if (req0_ready !== exp0) begin n_fail++; $display("FAIL cont_req0_ready%0d: got %b want %b", i, req0_ready, exp0); end
            n_tests++; if (req1_ready !== exp1) begin n_fail++; $display("FAIL cont_req1_ready%0d: got %b want %b", i, req1_ready, exp1); end
            tick();
            n_tests++; if (rf_wen !== 1'b1 || rf_waddr !== exp_addr) begin n_fail++; $display("FAIL cont_rf%0d: got wen=%b addr=%0d want wen=1 addr=%0d", i, rf_wen, rf_waddr, exp_addr); end
            $display("[TB] contention cycle %0d grant=%0d", i, exp1 ? 1 : 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        $display("[TB] test_contention done");
    endtask

    task automatic test_x0_unsolicited();
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_rf_wen: got %b want 0", rf_wen); end
        set_valid = 1'b1; set_addr = 5'd0; rs1_addr = 5'd0;
        #1;
        n_tests++; if (set_ready !== 1'b1) begin n_fail++; $display("FAIL x0_set_ready: got %b want 1", set_ready); end
        tick();
        set_valid = 1'b0;
        #1;
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL x0_hazard: got %b want 0", rs_hazard); end
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL unsol_ready: got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        rs1_addr = 5'd3;
        #1;
        n_tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin n_fail++; $display("FAIL unsol_rf: got wen=%b addr=%0d data=%h want 1/3/33", rf_wen, rf_waddr, rf_wdata); end
        tick();
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL unsol_no_underflow: got %b want 0", rs_hazard); end
        rs1_addr = '0;
        $display("[TB] test_x0_unsolicited done");
    endtask

    task automatic test_reset_mid();
        set_valid = 1'b1; set_addr = 5'd4; rs1_addr = 5'd4;
        tick();
        set_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_hs_ready: got %b want 1", req0_ready); end
        n_tests++; if (rs_hazard !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", rs_hazard); end
        tick();
        rst = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd8;
        set_valid  = 1'b1; set_addr  = 5'd4;
        #1;
        n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || set_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_readies: got r0=%b r1=%b set=%b want 0/0/0", req0_ready, req1_ready, set_ready); end
        tick();
        rst = 1'b0;
        idle_inputs();
        rs1_addr = 5'd4;
        #1;
        n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rmid_rf_wen: got %b want 0", rf_wen); end
        n_tests++; if (rs_hazard !== 1'b0) begin n_fail++; $display("FAIL rmid_hazard: got %b want 0", rs_hazard); end
        rs1_addr = '0;
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_hazard();
        test_saturation();
        test_contention();
        test_x0_unsolicited();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
